// File: rtl/synth_ctrl_pkg.sv
// rtl/synth_ctrl_pkg.sv - shared types, address map and helpers for the synth control register bank
//
// Purpose: global parameter struct, word-address map, stored field widths,
//          commit FSM state encoding and the byte-lane mask helper.
// Ports:   none (package).

package synth_ctrl_pkg;

  // Global word map
  localparam int ADDR_SHAPE1      = 0;
  localparam int ADDR_SHAPE0      = 1;
  localparam int ADDR_ATTACK      = 2;
  localparam int ADDR_DECAY       = 3;
  localparam int ADDR_SUSTAIN     = 4;
  localparam int ADDR_RLEASE      = 5;
  localparam int ADDR_GLIDE_EN    = 6;
  localparam int ADDR_GLIDE_RATE  = 7;
  localparam int ADDR_ARP_EN      = 8;
  localparam int ADDR_ARP_TIME    = 9;
  localparam int ADDR_PINGPONG_EN = 10;
  localparam int ADDR_PANNING     = 11;
  localparam int ADDR_AUTO_PAN_EN = 12;
  localparam int ADDR_COMMIT      = 14;
  localparam int ADDR_STATUS      = 15;

  // Voice groups: base + stride*v, fields KEY, FREQ, AMP1, AMP0 at +0..+3
  localparam int VOICE_BASE   = 16;
  localparam int VOICE_STRIDE = 4;

  // Stored field widths
  localparam int W_SHAPE      = 2;
  localparam int W_ENV        = 16;
  localparam int W_GLIDE_RATE = 25;
  localparam int W_ARP_TIME   = 16;
  localparam int W_PANNING    = 16;
  localparam int W_FREQ       = 7;
  localparam int W_AMP        = 16;

  typedef struct packed {
    logic [W_SHAPE-1:0]      shape1;
    logic [W_SHAPE-1:0]      shape0;
    logic [W_ENV-1:0]        attack;
    logic [W_ENV-1:0]        decay;
    logic [W_ENV-1:0]        sustain;
    logic [W_ENV-1:0]        rlease;
    logic                    glide_en;
    logic [W_GLIDE_RATE-1:0] glide_rate;
    logic                    arp_en;
    logic [W_ARP_TIME-1:0]   arp_time;
    logic                    pingpong_en;
    logic [W_PANNING-1:0]    panning;
    logic                    auto_pan_en;
  } synth_cfg_t;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } commit_state_e;

  // Expand 4 byte enables into a 32-bit bit mask
  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/synth_ctrl_commit_fsm.sv
// rtl/synth_ctrl_commit_fsm.sv - shadow-to-active commit sequencer with status and interrupt
//
// Purpose: tracks a pending commit, releases it on the next frame tick, counts
//          completed commits and drives the commit-done interrupt.
// Ports:   clk, resetn     - clock, synchronous active-low reset
//          frame_tick      - audio sample boundary pulse
//          commit_req      - commit strobe write accepted this cycle
//          done_clr        - W1C of the done flag this cycle
//          irq_en          - interrupt enable as it will be after this edge
//          copy_en         - combinational: copy shadow to active on this edge
//          pending, done   - status flags
//          commit_count    - completed commit counter (wraps)
//          irq             - registered done & irq_en

module synth_ctrl_commit_fsm
  import synth_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        frame_tick,
  input  logic        commit_req,
  input  logic        done_clr,
  input  logic        irq_en,
  output logic        copy_en,
  output logic        pending,
  output logic        done,
  output logic [15:0] commit_count,
  output logic        irq
);

  commit_state_e state_q, state_d;
  logic          done_q, done_d;
  logic [15:0]   count_q, count_d;
  logic          irq_q, irq_d;

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    count_d = count_q;
    // Must be combinational so the copy lands on the tick edge itself
    copy_en = (state_q == ST_PENDING) && frame_tick;
    if (done_clr) done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A tick in the same cycle as the request is not used for the copy
        if (commit_req) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (frame_tick) begin
          state_d = ST_IDLE;
          count_d = count_q + 16'd1;
          done_d  = 1'b1; // completion overrides a coincident clear
        end
      end
      default: state_d = ST_IDLE;
    endcase
    irq_d = done_d & irq_en;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      count_q <= 16'd0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      count_q <= count_d;
      irq_q   <= irq_d;
    end
  end

  assign pending      = (state_q == ST_PENDING);
  assign done         = done_q;
  assign commit_count = count_q;
  assign irq          = irq_q;

endmodule

// File: rtl/synth_ctrl_regbank.sv
// rtl/synth_ctrl_regbank.sv - double-buffered Avalon-MM control register bank for the synth
//
// Purpose: CPU writes a shadow bank with byte-lane masking; a commit copies the
//          whole shadow bank to the active outputs on the next frame tick.
//          Reads are registered with a one-cycle valid strobe.
// Ports:   CLK, RESET                       - clock, synchronous active-low reset
//          FRAME_TICK                       - audio sample boundary pulse
//          AVL_*                            - Avalon-MM slave (word addressed)
//          CFG, KEY, FREQ, AMP1, AMP0       - active parameters
//          IRQ                              - commit-done interrupt

module synth_ctrl_regbank
  import synth_ctrl_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int ADDR_W     = 6
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     FRAME_TICK,
  input  logic [ADDR_W-1:0]        AVL_ADDR,
  input  logic [3:0]               AVL_BYTE_EN,
  input  logic                     AVL_READ,
  input  logic                     AVL_WRITE,
  input  logic                     AVL_CS,
  input  logic [31:0]              AVL_WRITEDATA,
  output logic [31:0]              AVL_READDATA,
  output logic                     AVL_READDATAVALID,
  output synth_cfg_t               CFG,
  output logic [NUM_VOICES-1:0]    KEY,
  output logic [7*NUM_VOICES-1:0]  FREQ,
  output logic [16*NUM_VOICES-1:0] AMP1,
  output logic [16*NUM_VOICES-1:0] AMP0,
  output logic                     IRQ
);

  if (NUM_VOICES < 1 || NUM_VOICES > 32 ||
      VOICE_BASE + VOICE_STRIDE * NUM_VOICES > (1 << ADDR_W)) begin : g_bad_param
    $error("synth_ctrl_regbank: NUM_VOICES does not fit the address space");
  end

  synth_cfg_t                sh_cfg_q, sh_cfg_d, act_cfg_q, act_cfg_d;
  logic [NUM_VOICES-1:0]     sh_key_q, sh_key_d, act_key_q, act_key_d;
  logic [7*NUM_VOICES-1:0]   sh_freq_q, sh_freq_d, act_freq_q, act_freq_d;
  logic [16*NUM_VOICES-1:0]  sh_amp1_q, sh_amp1_d, act_amp1_q, act_amp1_d;
  logic [16*NUM_VOICES-1:0]  sh_amp0_q, sh_amp0_d, act_amp0_q, act_amp0_d;
  logic                      irq_en_q, irq_en_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      rvalid_q, rvalid_d;

  logic        wr, rd, is_voice, copy_en, pending, done, commit_req, done_clr;
  logic [15:0] commit_count;
  int          addr_i, vi, fld;
  logic [31:0] cur_val, wr_val;

  // Decode and current-value mux; the mux also feeds the byte-merge on writes
  always_comb begin
    wr       = AVL_WRITE & AVL_CS;
    rd       = AVL_READ & AVL_CS;
    addr_i   = int'(AVL_ADDR);
    is_voice = (addr_i >= VOICE_BASE) && (addr_i < VOICE_BASE + VOICE_STRIDE * NUM_VOICES);
    vi       = (addr_i - VOICE_BASE) / VOICE_STRIDE;
    fld      = (addr_i - VOICE_BASE) % VOICE_STRIDE;
    cur_val  = 32'd0;
    if (is_voice) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (vi == v) begin
          case (fld)
            0:       cur_val = 32'(sh_key_q[v]);
            1:       cur_val = 32'(sh_freq_q[7*v +: 7]);
            2:       cur_val = 32'(sh_amp1_q[16*v +: 16]);
            default: cur_val = 32'(sh_amp0_q[16*v +: 16]);
          endcase
        end
      end
    end else begin
      case (addr_i)
        ADDR_SHAPE1:      cur_val = 32'(sh_cfg_q.shape1);
        ADDR_SHAPE0:      cur_val = 32'(sh_cfg_q.shape0);
        ADDR_ATTACK:      cur_val = 32'(sh_cfg_q.attack);
        ADDR_DECAY:       cur_val = 32'(sh_cfg_q.decay);
        ADDR_SUSTAIN:     cur_val = 32'(sh_cfg_q.sustain);
        ADDR_RLEASE:      cur_val = 32'(sh_cfg_q.rlease);
        ADDR_GLIDE_EN:    cur_val = 32'(sh_cfg_q.glide_en);
        ADDR_GLIDE_RATE:  cur_val = 32'(sh_cfg_q.glide_rate);
        ADDR_ARP_EN:      cur_val = 32'(sh_cfg_q.arp_en);
        ADDR_ARP_TIME:    cur_val = 32'(sh_cfg_q.arp_time);
        ADDR_PINGPONG_EN: cur_val = 32'(sh_cfg_q.pingpong_en);
        ADDR_PANNING:     cur_val = 32'(sh_cfg_q.panning);
        ADDR_AUTO_PAN_EN: cur_val = 32'(sh_cfg_q.auto_pan_en);
        ADDR_COMMIT:      cur_val = {30'd0, irq_en_q, 1'b0};
        ADDR_STATUS:      cur_val = {commit_count, 14'd0, done, pending};
        default:          cur_val = 32'd0;
      endcase
    end
    wr_val = (cur_val & ~byte_mask(AVL_BYTE_EN)) | (AVL_WRITEDATA & byte_mask(AVL_BYTE_EN));
  end

  // Shadow writes, control strobes, active copy and read pipeline
  always_comb begin
    sh_cfg_d   = sh_cfg_q;
    sh_key_d   = sh_key_q;
    sh_freq_d  = sh_freq_q;
    sh_amp1_d  = sh_amp1_q;
    sh_amp0_d  = sh_amp0_q;
    irq_en_d   = irq_en_q;
    commit_req = wr && addr_i == ADDR_COMMIT && AVL_BYTE_EN[0] && AVL_WRITEDATA[0];
    done_clr   = wr && addr_i == ADDR_STATUS && AVL_BYTE_EN[0] && AVL_WRITEDATA[1];
    if (wr) begin
      if (is_voice) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (vi == v) begin
            case (fld)
              0:       sh_key_d[v]           = wr_val[0];
              1:       sh_freq_d[7*v +: 7]   = wr_val[6:0];
              2:       sh_amp1_d[16*v +: 16] = wr_val[15:0];
              default: sh_amp0_d[16*v +: 16] = wr_val[15:0];
            endcase
          end
        end
      end else begin
        case (addr_i)
          ADDR_SHAPE1:      sh_cfg_d.shape1      = wr_val[W_SHAPE-1:0];
          ADDR_SHAPE0:      sh_cfg_d.shape0      = wr_val[W_SHAPE-1:0];
          ADDR_ATTACK:      sh_cfg_d.attack      = wr_val[W_ENV-1:0];
          ADDR_DECAY:       sh_cfg_d.decay       = wr_val[W_ENV-1:0];
          ADDR_SUSTAIN:     sh_cfg_d.sustain     = wr_val[W_ENV-1:0];
          ADDR_RLEASE:      sh_cfg_d.rlease      = wr_val[W_ENV-1:0];
          ADDR_GLIDE_EN:    sh_cfg_d.glide_en    = wr_val[0];
          ADDR_GLIDE_RATE:  sh_cfg_d.glide_rate  = wr_val[W_GLIDE_RATE-1:0];
          ADDR_ARP_EN:      sh_cfg_d.arp_en      = wr_val[0];
          ADDR_ARP_TIME:    sh_cfg_d.arp_time    = wr_val[W_ARP_TIME-1:0];
          ADDR_PINGPONG_EN: sh_cfg_d.pingpong_en = wr_val[0];
          ADDR_PANNING:     sh_cfg_d.panning     = wr_val[W_PANNING-1:0];
          ADDR_AUTO_PAN_EN: sh_cfg_d.auto_pan_en = wr_val[0];
          ADDR_COMMIT:      if (AVL_BYTE_EN[0]) irq_en_d = AVL_WRITEDATA[1];
          default:          ;
        endcase
      end
    end
    // Copy takes the pre-write shadow (the _q side), so a coincident write waits for the next commit
    act_cfg_d  = copy_en ? sh_cfg_q  : act_cfg_q;
    act_key_d  = copy_en ? sh_key_q  : act_key_q;
    act_freq_d = copy_en ? sh_freq_q : act_freq_q;
    act_amp1_d = copy_en ? sh_amp1_q : act_amp1_q;
    act_amp0_d = copy_en ? sh_amp0_q : act_amp0_q;
    rvalid_d   = rd;
    rdata_d    = rd ? cur_val : 32'd0;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      sh_cfg_q   <= '0;
      sh_key_q   <= '0;
      sh_freq_q  <= '0;
      sh_amp1_q  <= '0;
      sh_amp0_q  <= '0;
      act_cfg_q  <= '0;
      act_key_q  <= '0;
      act_freq_q <= '0;
      act_amp1_q <= '0;
      act_amp0_q <= '0;
      irq_en_q   <= 1'b0;
      rdata_q    <= 32'd0;
      rvalid_q   <= 1'b0;
    end else begin
      sh_cfg_q   <= sh_cfg_d;
      sh_key_q   <= sh_key_d;
      sh_freq_q  <= sh_freq_d;
      sh_amp1_q  <= sh_amp1_d;
      sh_amp0_q  <= sh_amp0_d;
      act_cfg_q  <= act_cfg_d;
      act_key_q  <= act_key_d;
      act_freq_q <= act_freq_d;
      act_amp1_q <= act_amp1_d;
      act_amp0_q <= act_amp0_d;
      irq_en_q   <= irq_en_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  synth_ctrl_commit_fsm u_commit_fsm (
    .clk          (CLK),
    .resetn       (RESET),
    .frame_tick   (FRAME_TICK),
    .commit_req   (commit_req),
    .done_clr     (done_clr),
    .irq_en       (irq_en_d),
    .copy_en      (copy_en),
    .pending      (pending),
    .done         (done),
    .commit_count (commit_count),
    .irq          (IRQ)
  );

  assign AVL_READDATA      = rdata_q;
  assign AVL_READDATAVALID = rvalid_q;
  assign CFG               = act_cfg_q;
  assign KEY               = act_key_q;
  assign FREQ              = act_freq_q;
  assign AMP1              = act_amp1_q;
  assign AMP0              = act_amp0_q;

endmodule

// File: tb/tb_synth_ctrl_regbank.sv
// tb/tb_synth_ctrl_regbank.sv - directed self-checking bench for synth_ctrl_regbank

module tb_synth_ctrl_regbank;
  import synth_ctrl_pkg::*;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         FRAME_TICK = 1'b0;
  logic [5:0]   AVL_ADDR = '0;
  logic [3:0]   AVL_BYTE_EN = '0;
  logic         AVL_READ = 1'b0;
  logic         AVL_WRITE = 1'b0;
  logic         AVL_CS = 1'b0;
  logic [31:0]  AVL_WRITEDATA = '0;
  logic [31:0]  AVL_READDATA;
  logic         AVL_READDATAVALID;
  synth_cfg_t   CFG;
  logic [7:0]   KEY;
  logic [55:0]  FREQ;
  logic [127:0] AMP1;
  logic [127:0] AMP0;
  logic         IRQ;

  int n_checks = 0;
  int n_fail   = 0;

  synth_ctrl_regbank #(.NUM_VOICES(8), .ADDR_W(6)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .FRAME_TICK        (FRAME_TICK),
    .AVL_ADDR          (AVL_ADDR),
    .AVL_BYTE_EN       (AVL_BYTE_EN),
    .AVL_READ          (AVL_READ),
    .AVL_WRITE         (AVL_WRITE),
    .AVL_CS            (AVL_CS),
    .AVL_WRITEDATA     (AVL_WRITEDATA),
    .AVL_READDATA      (AVL_READDATA),
    .AVL_READDATAVALID (AVL_READDATAVALID),
    .CFG               (CFG),
    .KEY               (KEY),
    .FREQ              (FREQ),
    .AMP1              (AMP1),
    .AMP0              (AMP0),
    .IRQ               (IRQ)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Write with optional FRAME_TICK in the same cycle
  task automatic avl_write(input int addr, input logic [31:0] data, input logic [3:0] be,
                           input logic with_tick);
    AVL_ADDR      = 6'(addr);
    AVL_WRITEDATA = data;
    AVL_BYTE_EN   = be;
    AVL_WRITE     = 1'b1;
    AVL_CS        = 1'b1;
    FRAME_TICK    = with_tick;
    tick();
    AVL_WRITE     = 1'b0;
    AVL_CS        = 1'b0;
    FRAME_TICK    = 1'b0;
  endtask

  task automatic read_check(input string tag, input int addr, input logic [31:0] exp);
    AVL_ADDR = 6'(addr);
    AVL_READ = 1'b1;
    AVL_CS   = 1'b1;
    tick();
    AVL_READ = 1'b0;
    AVL_CS   = 1'b0;
    check_eq({tag, "_valid"}, 32'(AVL_READDATAVALID), 32'd1);
    check_eq(tag, AVL_READDATA, exp);
  endtask

  task automatic frame();
    FRAME_TICK = 1'b1;
    tick();
    FRAME_TICK = 1'b0;
  endtask

  logic [6:0] f7;

  initial begin
    // 1: reset state and read latency
    RESET = 1'b0;
    repeat (3) tick();
    RESET = 1'b1;
    tick();
    check_eq("rst_key", 32'(KEY), 32'd0);
    check_eq("rst_irq", 32'(IRQ), 32'd0);
    check_eq("rst_rvalid", 32'(AVL_READDATAVALID), 32'd0);
    read_check("rd_attack_rst", 2, 32'd0);
    tick();
    check_eq("rvalid_one_cycle", 32'(AVL_READDATAVALID), 32'd0);
    check_eq("rdata_zero_idle", AVL_READDATA, 32'd0);
    read_check("rd_status_rst", 15, 32'd0);

    // 2: shadow write, commit, frame tick copy
    avl_write(2, 32'h0000_1234, 4'hF, 1'b0);
    read_check("rd_attack", 2, 32'h0000_1234);
    check_eq("act_attack_pre", 32'(CFG.attack), 32'd0);
    avl_write(14, 32'h1, 4'h1, 1'b0);
    check_eq("act_attack_pend", 32'(CFG.attack), 32'd0);
    read_check("status_pend", 15, 32'h0000_0001);
    frame();
    check_eq("act_attack", 32'(CFG.attack), 32'h1234);
    read_check("status_c1", 15, 32'h0001_0002);

    // 3: byte-lane masking on a 25-bit field
    avl_write(7, 32'hAABB_CCDD, 4'b0101, 1'b0);
    read_check("rd_glide_mask", 7, 32'h00BB_00DD);
    avl_write(14, 32'h1, 4'h1, 1'b0);
    frame();
    check_eq("act_glide", 32'(CFG.glide_rate), 32'h00BB_00DD);
    avl_write(7, 32'hFFFF_FFFF, 4'b0010, 1'b0);
    read_check("rd_glide_merge", 7, 32'h00BB_FFDD);
    avl_write(7, 32'hFFFF_FFFF, 4'b1000, 1'b0);
    read_check("rd_glide_bit24", 7, 32'h01BB_FFDD);

    // 4: last voice, voice 0 amplitude, unmapped and reserved addresses
    avl_write(44, 32'h1, 4'hF, 1'b0);
    avl_write(45, 32'd60, 4'hF, 1'b0);
    avl_write(18, 32'h0000_BEEF, 4'hF, 1'b0);
    avl_write(48, 32'hFFFF_FFFF, 4'hF, 1'b0);
    avl_write(13, 32'hFFFF_FFFF, 4'hF, 1'b0);
    read_check("rd_freq7", 45, 32'd60);
    read_check("rd_unmapped", 48, 32'd0);
    read_check("rd_reserved", 13, 32'd0);
    avl_write(14, 32'h1, 4'h1, 1'b0);
    check_eq("key_pre", 32'(KEY), 32'd0);
    frame();
    check_eq("key_v7", 32'(KEY), 32'h80);
    f7 = FREQ[55:49];
    check_eq("freq_v7", 32'(f7), 32'd60);
    check_eq("amp1_v0", 32'(AMP1[15:0]), 32'hBEEF);
    read_check("status_c3", 15, 32'h0003_0002);

    // 5: commit on tick edge defers; shadow write on copy edge
    avl_write(3, 32'h1111, 4'hF, 1'b0);
    avl_write(14, 32'h1, 4'h1, 1'b0);
    frame();
    check_eq("act_decay1", 32'(CFG.decay), 32'h1111);
    avl_write(3, 32'h2222, 4'hF, 1'b0);
    avl_write(14, 32'h1, 4'h1, 1'b1);
    read_check("status_same_tick", 15, 32'h0004_0003);
    check_eq("act_decay_hold", 32'(CFG.decay), 32'h1111);
    avl_write(14, 32'h1, 4'h1, 1'b0);
    read_check("status_commit_pend", 15, 32'h0004_0003);
    avl_write(3, 32'h3333, 4'hF, 1'b1);
    check_eq("act_decay_prewrite", 32'(CFG.decay), 32'h2222);
    read_check("rd_decay_new", 3, 32'h3333);
    read_check("status_c5", 15, 32'h0005_0002);

    // 6: interrupt, W1C vs completion, reset while pending
    avl_write(15, 32'h2, 4'h1, 1'b0);
    read_check("status_w1c", 15, 32'h0005_0000);
    avl_write(14, 32'h2, 4'h1, 1'b0);
    read_check("rd_commit", 14, 32'h2);
    check_eq("irq_idle", 32'(IRQ), 32'd0);
    avl_write(14, 32'h3, 4'h1, 1'b0);
    frame();
    check_eq("irq_set", 32'(IRQ), 32'd1);
    avl_write(15, 32'h2, 4'h1, 1'b0);
    check_eq("irq_clr", 32'(IRQ), 32'd0);
    avl_write(14, 32'h3, 4'h1, 1'b0);
    avl_write(15, 32'h2, 4'h1, 1'b1);
    check_eq("irq_set_wins", 32'(IRQ), 32'd1);
    read_check("status_set_wins", 15, 32'h0007_0002);
    avl_write(14, 32'h3, 4'h1, 1'b0);
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    check_eq("irq_after_rst", 32'(IRQ), 32'd0);
    read_check("status_after_rst", 15, 32'd0);
    avl_write(3, 32'h4444, 4'hF, 1'b0);
    frame();
    check_eq("no_copy_after_rst", 32'(CFG.decay), 32'd0);
    check_eq("attack_after_rst", 32'(CFG.attack), 32'd0);
    read_check("status_no_commit", 15, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/synth_ctrl_regbank.md
Name: synth_ctrl_regbank

Overview:
Parametrised Avalon-MM control register bank for the synth. It replaces the flat 64-word control file with a double-buffered, NUM_VOICES-scalable map. The CPU writes a shadow bank. A COMMIT request copies shadow to active atomically on the next audio frame boundary, so voice and envelope parameters never change mid-sample. It adds byte-enable masking, registered reads with a valid strobe, a status register and a commit-done interrupt.

Parameters:
NUM_VOICES, 8, number of voice register groups (1..32).
ADDR_W, 6, Avalon word-address width; elaboration error unless 16+4*NUM_VOICES <= 2**ADDR_W.

Ports:
CLK  in  1  system clock.
RESET  in  1  synchronous, active-low reset (RESET=0 resets on the CLK edge).
FRAME_TICK  in  1  one-cycle pulse at each audio sample boundary.
AVL_ADDR  in  ADDR_W  word address.
AVL_BYTE_EN  in  4  write byte lanes.
AVL_READ  in  1  read request.
AVL_WRITE  in  1  write request.
AVL_CS  in  1  chip select.
AVL_WRITEDATA  in  32  write data.
AVL_READDATA  out  32  registered read data.
AVL_READDATAVALID  out  1  pulses with AVL_READDATA.
CFG  out  synth_cfg_t  active global parameters (struct).
KEY  out  NUM_VOICES  active key-down bits.
FREQ  out  7*NUM_VOICES  active note numbers; voice v at [7v+6:7v].
AMP1  out  16*NUM_VOICES  active osc1 amplitudes; voice v at [16v+15:16v].
AMP0  out  16*NUM_VOICES  active osc0 amplitudes; same packing.
IRQ  out  1  commit-done interrupt.

Behaviour:
- Global word map, with stored field width in brackets:
  - 0 SHAPE1[1:0], 1 SHAPE0[1:0], 2 ATTACK[15:0], 3 DECAY[15:0], 4 SUSTAIN[15:0], 5 RLEASE[15:0].
  - 6 GLIDE_EN[0], 7 GLIDE_RATE[24:0], 8 ARP_EN[0], 9 ARP_TIME[15:0], 10 PINGPONG_EN[0], 11 PANNING[15:0], 12 AUTO_PAN_EN[0].
  - 13 reserved.
  - 14 COMMIT: bit0 commit strobe (write-only, reads 0); bit1 IRQ_EN (R/W, not shadowed).
  - 15 STATUS (read-only): [31:16] commit_count, bit1 done (W1C), bit0 pending.
- Voice v base address = 16+4v: +0 KEY[0], +1 FREQ[6:0], +2 AMP1[15:0], +3 AMP0[15:0].
- Only defined field bits are stored; unused bits read 0.
- Write (AVL_WRITE & AVL_CS): updates shadow on the next edge, masked per byte lane by AVL_BYTE_EN. Writes to reserved or unmapped addresses are ignored. AVL_READ and AVL_WRITE are never asserted together.
- Read (AVL_READ & AVL_CS): fixed 1-cycle latency. AVL_READDATA and AVL_READDATAVALID are registered; VALID is high exactly one cycle per accepted read. Data is the shadow value, or COMMIT/STATUS as defined; unmapped addresses return 0. AVL_READDATA = 0 whenever VALID = 0. Back-to-back reads return back-to-back data.
- Commit FSM, states IDLE and PENDING:
  - IDLE → PENDING on a write to COMMIT with bit0=1 and byte lane 0 enabled.
  - PENDING → IDLE on a cycle with FRAME_TICK=1. That edge copies the whole shadow bank to active, increments commit_count (wraps 0xFFFF→0) and sets done.
  - A commit write in the same cycle as FRAME_TICK while IDLE enters PENDING; the copy happens at the next FRAME_TICK, not that one.
  - A commit write while PENDING has no effect.
  - A shadow write on the copy edge: active receives the pre-write shadow value; shadow receives the new data.
- IRQ = done & IRQ_EN, registered. Writing STATUS bit1=1 clears done. If the clear coincides with a commit completion, set wins.
- Reset: shadow, active, IRQ_EN, commit_count and done all 0; FSM IDLE; all outputs 0. Reset while PENDING discards the commit.

Decomposition:
- Package synth_ctrl_pkg holds:
  - synth_cfg_t packed struct with the global fields above.
  - Address localparams: ADDR_SHAPE1..ADDR_AUTO_PAN_EN, ADDR_COMMIT=14, ADDR_STATUS=15, VOICE_BASE=16, VOICE_STRIDE=4.
  - Field-width localparams.
  - Byte-lane mask function.
- One sub-module, synth_ctrl_commit_fsm: owns pending/done/commit_count/IRQ and outputs the copy-enable pulse.

Test Plan:
1. Reset then read addresses 2 and 15 → AVL_READDATAVALID one cycle after each read; data 0; KEY=0; IRQ=0.
2. Write 0x1234 to ATTACK (addr 2) → shadow read returns 0x1234; CFG.attack stays 0 until a COMMIT write plus FRAME_TICK, then 0x1234; STATUS=0x0001_0002.
3. Write 0xAABBCCDD to addr 7 with BYTE_EN=4'b0101 → reads 0x00BB00DD; after commit, GLIDE_RATE=0x0BB00DD.
4. NUM_VOICES=8: write 1 to addr 44 (voice 7 KEY) and 60 to addr 45, commit → KEY=8'h80, FREQ[55:49]=60; an addr 48 write is ignored and reads 0.
5. Commit write on the same cycle as FRAME_TICK → STATUS.pending=1, active unchanged; next FRAME_TICK copies; a shadow write on the copy edge leaves the old value in active.
6. IRQ_EN=1, commit completes → IRQ=1; W1C STATUS bit1 on the cycle a second commit completes → done stays 1, IRQ stays 1; RESET=0 mid-PENDING → pending=0, no copy on the next FRAME_TICK.
